// File: rtl/regfile_sb_pkg.sv
// Shared defaults and helpers for the scoreboarded register file.
package regfile_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 3;

  // True when addr names the hardwired-zero register and that feature is on.
  // Callers zero-extend their address to 32 bits.
  function automatic logic addr_is_zero(input logic [31:0] addr, input logic zero_reg);
    return zero_reg && (addr == 32'd0);
  endfunction

endpackage

// File: rtl/regfile_sb_if.sv
// Write, reserve and dual-read bus of the register file.
interface regfile_sb_if
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) ();

  logic              wen;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] din;
  logic              rsv_en;
  logic [ADDR_W-1:0] rsv_addr;
  logic [ADDR_W-1:0] a_addr;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] a_out;
  logic [DATA_W-1:0] b_out;
  logic              a_busy;
  logic              b_busy;

  modport master (
    output wen, w_addr, din, rsv_en, rsv_addr, a_addr, b_addr,
    input  a_out, b_out, a_busy, b_busy
  );

  modport slave (
    input  wen, w_addr, din, rsv_en, rsv_addr, a_addr, b_addr,
    output a_out, b_out, a_busy, b_busy
  );

endinterface

// File: rtl/regfile_sb_onehot_dec.sv
// Enable-gated binary to one-hot decoder; every address value decodes.
module onehot_dec #(
  parameter int ADDR_W = 3
) (
  input  logic                     en,
  input  logic [ADDR_W-1:0]        addr,
  output logic [(1<<ADDR_W)-1:0]   onehot
);

  // single hot bit at addr, all zero when disabled
  always_comb begin
    onehot       = '0;
    onehot[addr] = en;
  end

endmodule

// File: rtl/regfile_sb.sv
// Register file: 2 registered read ports, 1 write port with write-to-read
// bypass, and a per-register busy bit tracking outstanding producers.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int ZERO_REG = 0
) (
  input logic         clk,
  input logic         rst,
  regfile_sb_if.slave bus
);

  localparam int   DEPTH    = 1 << ADDR_W;
  localparam logic HAS_ZERO = (ZERO_REG != 0);

  logic                         wr_en;
  logic                         rsv_en;
  logic [DEPTH-1:0]             wr_sel;
  logic [DEPTH-1:0]             rsv_sel;
  logic [DEPTH-1:0]             busy_q;
  logic [DEPTH-1:0]             busy_nxt;
  logic [DEPTH-1:0][DATA_W-1:0] mem;
  logic                         byp_a;
  logic                         byp_b;

  // r0 traffic is dropped before decode when it is hardwired to zero, so the
  // bypass and busy paths below never see it.
  assign wr_en  = bus.wen    & ~addr_is_zero(32'(bus.w_addr),   HAS_ZERO);
  assign rsv_en = bus.rsv_en & ~addr_is_zero(32'(bus.rsv_addr), HAS_ZERO);

  onehot_dec #(.ADDR_W(ADDR_W)) u_wr_dec (
    .en     (wr_en),
    .addr   (bus.w_addr),
    .onehot (wr_sel)
  );

  onehot_dec #(.ADDR_W(ADDR_W)) u_rsv_dec (
    .en     (rsv_en),
    .addr   (bus.rsv_addr),
    .onehot (rsv_sel)
  );

  // Post-edge busy: a reservation beats a retiring write on the same register.
  assign busy_nxt = rsv_sel | (busy_q & ~wr_sel);

  for (genvar i = 0; i < DEPTH; i++) begin : g_reg
    if (HAS_ZERO && i == 0) begin : g_zero
      assign mem[i]    = '0;
      assign busy_q[i] = 1'b0;
    end else begin : g_store
      logic [DATA_W-1:0] data_q;
      logic              busy_r;

      // storage cell, loaded by its decoded write enable
      always_ff @(posedge clk or posedge rst) begin
        if (rst)            data_q <= '0;
        else if (wr_sel[i]) data_q <= bus.din;
      end

      // busy flag follows the combined reserve/retire result
      always_ff @(posedge clk or posedge rst) begin
        if (rst) busy_r <= 1'b0;
        else     busy_r <= busy_nxt[i];
      end

      assign mem[i]    = data_q;
      assign busy_q[i] = busy_r;
    end
  end

  // A write landing on the addressed register this edge is forwarded.
  assign byp_a = wr_sel[bus.a_addr];
  assign byp_b = wr_sel[bus.b_addr];

  // registered read ports; busy is always the post-edge value
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.a_out  <= '0;
      bus.b_out  <= '0;
      bus.a_busy <= 1'b0;
      bus.b_busy <= 1'b0;
    end else begin
      bus.a_out  <= byp_a ? bus.din : mem[bus.a_addr];
      bus.b_out  <= byp_b ? bus.din : mem[bus.b_addr];
      bus.a_busy <= busy_nxt[bus.a_addr];
      bus.b_busy <= busy_nxt[bus.b_addr];
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb: three instances (16x8 plain, 16x8 with
// hardwired r0, 32x32 plain) share one clock and reset.
module tb_regfile_sb;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  regfile_sb_if #(.DATA_W(16), .ADDR_W(3)) if0 ();
  regfile_sb_if #(.DATA_W(16), .ADDR_W(3)) if1 ();
  regfile_sb_if #(.DATA_W(32), .ADDR_W(5)) if2 ();

  regfile_sb #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(0)) u_dut0 (.clk(clk), .rst(rst), .bus(if0));
  regfile_sb #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(1)) u_dut1 (.clk(clk), .rst(rst), .bus(if1));
  regfile_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(0)) u_dut2 (.clk(clk), .rst(rst), .bus(if2));

  typedef struct {
    int          due;
    int          d;
    bit          ca;
    logic [31:0] ea;
    logic        eab;
    bit          cb;
    logic [31:0] eb;
    logic        ebb;
    string       nm;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] act_a(input int d);
    case (d)
      0:       return 32'(if0.a_out);
      1:       return 32'(if1.a_out);
      default: return if2.a_out;
    endcase
  endfunction

  function automatic logic [31:0] act_b(input int d);
    case (d)
      0:       return 32'(if0.b_out);
      1:       return 32'(if1.b_out);
      default: return if2.b_out;
    endcase
  endfunction

  function automatic logic act_ab(input int d);
    case (d)
      0:       return if0.a_busy;
      1:       return if1.a_busy;
      default: return if2.a_busy;
    endcase
  endfunction

  function automatic logic act_bb(input int d);
    case (d)
      0:       return if0.b_busy;
      1:       return if1.b_busy;
      default: return if2.b_busy;
    endcase
  endfunction

  task automatic idle_all();
    if0.wen = 0; if0.w_addr = '0; if0.din = '0; if0.rsv_en = 0; if0.rsv_addr = '0; if0.a_addr = '0; if0.b_addr = '0;
    if1.wen = 0; if1.w_addr = '0; if1.din = '0; if1.rsv_en = 0; if1.rsv_addr = '0; if1.a_addr = '0; if1.b_addr = '0;
    if2.wen = 0; if2.w_addr = '0; if2.din = '0; if2.rsv_en = 0; if2.rsv_addr = '0; if2.a_addr = '0; if2.b_addr = '0;
  endtask

  task automatic drive(input int d, input bit we, input int wa, input logic [31:0] wd,
                       input bit rs, input int ra, input int aa, input int ba);
    idle_all();
    case (d)
      0: begin
        if0.wen = we; if0.w_addr = 3'(wa); if0.din = wd[15:0];
        if0.rsv_en = rs; if0.rsv_addr = 3'(ra); if0.a_addr = 3'(aa); if0.b_addr = 3'(ba);
      end
      1: begin
        if1.wen = we; if1.w_addr = 3'(wa); if1.din = wd[15:0];
        if1.rsv_en = rs; if1.rsv_addr = 3'(ra); if1.a_addr = 3'(aa); if1.b_addr = 3'(ba);
      end
      default: begin
        if2.wen = we; if2.w_addr = 5'(wa); if2.din = wd;
        if2.rsv_en = rs; if2.rsv_addr = 5'(ra); if2.a_addr = 5'(aa); if2.b_addr = 5'(ba);
      end
    endcase
  endtask

  // One edge of stimulus; the expected read result is queued for the monitor.
  task automatic op(input int d, input bit we, input int wa, input logic [31:0] wd,
                    input bit rs, input int ra, input int aa, input int ba,
                    input bit ca, input logic [31:0] ea, input logic eab,
                    input bit cb, input logic [31:0] eb, input logic ebb, input string nm);
    exp_t e;
    @(negedge clk);
    drive(d, we, wa, wd, rs, ra, aa, ba);
    if (ca || cb) begin
      e.due = cyc + 1; e.d = d;
      e.ca = ca; e.ea = ea; e.eab = eab;
      e.cb = cb; e.eb = eb; e.ebb = ebb;
      e.nm = nm;
      sb.push_back(e);
    end
  endtask

  task automatic reset_chk(input int d, input string tag);
    chk({tag, "_a_out"},  act_a(d), 32'h0);
    chk({tag, "_b_out"},  act_b(d), 32'h0);
    chk({tag, "_a_busy"}, 32'(act_ab(d)), 32'h0);
    chk({tag, "_b_busy"}, 32'(act_bb(d)), 32'h0);
  endtask

  // monitor: read data is due on the falling edge after the sampling edge
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      automatic exp_t e = sb.pop_front();
      if (e.due != cyc) begin
        total++; bad++;
        $display("FAIL %s_late: due %0d checked %0d", e.nm, e.due, cyc);
      end else begin
        if (e.ca) begin
          chk({e.nm, "_a_out"},  act_a(e.d), e.ea);
          chk({e.nm, "_a_busy"}, 32'(act_ab(e.d)), 32'(e.eab));
        end
        if (e.cb) begin
          chk({e.nm, "_b_out"},  act_b(e.d), e.eb);
          chk({e.nm, "_b_busy"}, 32'(act_bb(e.d)), 32'(e.ebb));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time %0t limit 200000", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    idle_all();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    reset_chk(0, "init0");
    reset_chk(1, "init1");
    reset_chk(2, "init2");
    rst = 1'b0;

    // --- plain 16x8 file ---
    op(0, 0, 0, 0, 0, 0, 0, 7, 1, 32'h0, 0, 1, 32'h0, 0, "post_rst_read");
    for (int k = 0; k < 8; k++)
      op(0, 1, k, 32'h1000 + 32'(k), 0, 0, k, k, 1, 32'h1000 + 32'(k), 0, 1, 32'h1000 + 32'(k), 0, "fill_byp");
    op(0, 0, 0, 0, 0, 0, 3, 6, 1, 32'h1003, 0, 1, 32'h1006, 0, "fill_read");
    op(0, 0, 0, 0, 1, 1, 1, 3, 1, 32'h1001, 1, 1, 32'h1003, 0, "rsv_r1");

    // asynchronous reset in the middle of a cycle
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 1, 3);
    @(posedge clk);
    #2;
    chk("pre_rst_a_out", act_a(0), 32'h1001);
    chk("pre_rst_a_busy", 32'(act_ab(0)), 32'h1);
    rst = 1'b1;
    #1;
    reset_chk(0, "mid_rst");
    @(negedge clk);
    rst = 1'b0;
    op(0, 0, 0, 0, 0, 0, 1, 3, 1, 32'h0, 0, 1, 32'h0, 0, "rst_cleared");

    // write then read one cycle later
    op(0, 1, 5, 32'h1234, 0, 0, 0, 0, 1, 32'h0, 0, 1, 32'h0, 0, "wr_r5");
    op(0, 0, 0, 0, 0, 0, 5, 5, 1, 32'h1234, 0, 1, 32'h1234, 0, "rd_r5");

    // bypass on both ports
    op(0, 1, 3, 32'hBEEF, 0, 0, 3, 3, 1, 32'hBEEF, 0, 1, 32'hBEEF, 0, "bypass_r3");
    op(0, 0, 0, 0, 0, 0, 3, 5, 1, 32'hBEEF, 0, 1, 32'h1234, 0, "rd_r3");

    // busy scoreboard
    op(0, 0, 0, 0, 1, 2, 0, 2, 0, 0, 0, 1, 32'h0, 1, "rsv_r2");
    op(0, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0, 1, 32'h0, 1, "busy_r2");
    op(0, 1, 2, 32'h00AA, 0, 0, 0, 2, 0, 0, 0, 1, 32'h00AA, 0, "wr_r2_byp");
    op(0, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0, 1, 32'h00AA, 0, "retired_r2");
    op(0, 1, 2, 32'h00AA, 1, 2, 0, 2, 0, 0, 0, 1, 32'h00AA, 1, "rsv_wr_r2");
    op(0, 0, 0, 0, 0, 0, 2, 2, 1, 32'h00AA, 1, 1, 32'h00AA, 1, "same_addr_r2");
    op(0, 0, 0, 0, 1, 2, 0, 2, 0, 0, 0, 1, 32'h00AA, 1, "re_rsv_r2");
    op(0, 1, 4, 32'h4444, 1, 6, 4, 6, 1, 32'h4444, 0, 1, 32'h0, 1, "wr4_rsv6");
    op(0, 1, 6, 32'h6666, 0, 0, 6, 2, 1, 32'h6666, 0, 1, 32'h00AA, 1, "wr_r6");
    op(0, 0, 0, 0, 0, 0, 6, 4, 1, 32'h6666, 0, 1, 32'h4444, 0, "rd_r6_r4");

    // r0 is ordinary without the zero-register option
    op(0, 1, 0, 32'hFFFF, 1, 0, 0, 0, 1, 32'hFFFF, 1, 1, 32'hFFFF, 1, "z0_wr_rsv_r0");
    op(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hFFFF, 1, 1, 32'hFFFF, 1, "z0_rd_r0");

    // --- hardwired r0 ---
    op(1, 1, 0, 32'hFFFF, 1, 0, 0, 0, 1, 32'h0, 0, 1, 32'h0, 0, "z1_wr_rsv_r0");
    op(1, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0, 0, 1, 32'h0, 0, "z1_rd_r0");
    op(1, 1, 1, 32'h0101, 1, 1, 1, 0, 1, 32'h0101, 1, 1, 32'h0, 0, "z1_r1");
    op(1, 0, 0, 0, 0, 0, 1, 1, 1, 32'h0101, 1, 1, 32'h0101, 1, "z1_rd_r1");

    // --- 32x32 sweep ---
    for (int k = 0; k < 32; k++)
      op(2, 1, k, 32'(k) * 32'h01010101, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "");
    for (int k = 0; k < 32; k++)
      op(2, 0, 0, 0, 0, 0, k, 31 - k, 1, 32'(k) * 32'h01010101, 0,
         1, 32'(31 - k) * 32'h01010101, 0, "sweep");
    op(2, 1, 31, 32'hDEADBEEF, 1, 31, 31, 30, 1, 32'hDEADBEEF, 1, 1, 32'h1E1E1E1E, 0, "w32_byp_rsv");
    op(2, 0, 0, 0, 0, 0, 31, 31, 1, 32'hDEADBEEF, 1, 1, 32'hDEADBEEF, 1, "w32_rd");

    @(negedge clk);
    idle_all();
    repeat (3) @(negedge clk);
    if (sb.size() != 0) begin
      total++; bad++;
      $display("FAIL drain: pending %0d want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
